// File: rtl/sprite_line_buffer_ng_if.sv
// -----------------------------------------------------------------------------
// sprite_line_buffer_ng_if
// Write-side bundle between the sprite fetcher and the line buffer.
//   wr_req      fetcher -> buffer   toggle request (pending while != wr_ack)
//   wr_ack      buffer  -> fetcher  toggle acknowledge
//   data_in     fetcher -> buffer   PLANES bitplanes of TILE_W pixels,
//                                   plane p at [p*TILE_W +: TILE_W], MSB = leftmost
//   color_in    fetcher -> buffer   palette bank for the row
//   position_in fetcher -> buffer   X of the leftmost pixel
//   flip_in     fetcher -> buffer   1 = emit pixels LSB first
//   busy        buffer  -> fetcher  clear sweep running, unpacking, or request pending
// -----------------------------------------------------------------------------
interface sprite_line_buffer_ng_if #(
    parameter int ADDR_W     = 10,
    parameter int TILE_W     = 16,
    parameter int PLANES     = 4,
    parameter int COLOR_BITS = 4
);
    logic                     wr_req;
    logic                     wr_ack;
    logic [PLANES*TILE_W-1:0] data_in;
    logic [COLOR_BITS-1:0]    color_in;
    logic [ADDR_W-1:0]        position_in;
    logic                     flip_in;
    logic                     busy;

    modport master (
        output wr_req, data_in, color_in, position_in, flip_in,
        input  wr_ack, busy
    );

    modport slave (
        input  wr_req, data_in, color_in, position_in, flip_in,
        output wr_ack, busy
    );
endinterface

// File: rtl/sprite_line_buffer_ng.sv
// -----------------------------------------------------------------------------
// sprite_line_buffer_ng
// Double-buffered sprite line buffer. One bank is filled by unpacking tile rows
// (one pixel per clock), the other is scanned out on CE_PIX and cleared behind
// the scan. V0 selects which bank plays which role.
//
// Ports:
//   CLK_96M    sole clock
//   RESET      asynchronous active-high reset; starts the clear sweep
//   CE_PIX     pixel strobe
//   V0         line parity: 0 = read bank0 / write bank1, 1 = the reverse
//   NL         mirror readout (read address = scan_pos ^ all-ones)
//   wr         write-side bundle (slave modport of sprite_line_buffer_ng_if)
//   pixel_out  {colour, planes}; 0 = transparent; valid 2 clocks after CE_PIX
//
// Optional build macro: SPRITE_LB_PRIORITY_EN
//   defined   : per-bank occupancy map, first opaque pixel at an address wins
//   undefined : last opaque write wins
//
// state  | meaning
// CLEAR  | zeroing address clr_addr of both banks, one address per clock
// IDLE   | waiting for a toggle request
// UNPACK | writing one pixel of the latched row per clock
// -----------------------------------------------------------------------------
module sprite_line_buffer_ng #(
    parameter int ADDR_W     = 10,
    parameter int TILE_W     = 16,
    parameter int PLANES     = 4,
    parameter int COLOR_BITS = 4,
    parameter int SCAN_START = 249
) (
    input  logic                         CLK_96M,
    input  logic                         RESET,
    input  logic                         CE_PIX,
    input  logic                         V0,
    input  logic                         NL,
    sprite_line_buffer_ng_if.slave       wr,
    output logic [COLOR_BITS+PLANES-1:0] pixel_out
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int PIX_W = COLOR_BITS + PLANES;
    localparam int CNT_W = $clog2(TILE_W + 1);
    localparam int BIT_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;

    typedef enum logic [1:0] {CLEAR, IDLE, UNPACK} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]        clr_addr;
    logic [ADDR_W-1:0]        scan_pos;
    logic [ADDR_W-1:0]        rd_addr;
    logic [ADDR_W-1:0]        wr_addr;
    logic                     old_v0;
    logic                     v0_edge;
    logic                     rd_en;
    logic                     wr_ack_q;
    logic [CNT_W-1:0]         count;
    logic [PLANES*TILE_W-1:0] data_q;
    logic [COLOR_BITS-1:0]    color_q;
    logic [ADDR_W-1:0]        pos_q;
    logic                     flip_q;
    logic                     accept;
    logic                     pix_we;
    logic [CNT_W-1:0]         pix_idx;
    logic [BIT_W-1:0]         bit_sel;
    logic [TILE_W-1:0]        plane_word;
    logic [PLANES-1:0]        wr_planes;
    logic                     opaque;
    logic                     occ_hit;

    logic [PIX_W-1:0]         mem [2][DEPTH];
    logic [PIX_W-1:0]         rd_s1, rd_s2;
    logic                     rd_v1, rd_v2;

    // Read bank index is old_v0, write bank is its complement. Readout is
    // suppressed on the V0 edge clock, so old_v0 always equals V0 when used.
    assign v0_edge = (V0 != old_v0);
    assign rd_en   = CE_PIX && !v0_edge;
    assign rd_addr = scan_pos ^ {ADDR_W{NL}};

    assign wr.wr_ack = wr_ack_q;
    assign wr.busy   = (state_q != IDLE) || (wr.wr_req != wr_ack_q);

    // count runs TILE_W..1 while unpacking, so the pixel index is TILE_W-count.
    assign pix_idx = CNT_W'(TILE_W) - count;
    assign bit_sel = flip_q ? pix_idx[BIT_W-1:0]
                            : BIT_W'(TILE_W - 1) - pix_idx[BIT_W-1:0];
    assign wr_addr = pos_q + ADDR_W'(pix_idx);

    always_comb begin
        plane_word = '0;
        wr_planes  = '0;
        for (int p = 0; p < PLANES; p++) begin
            plane_word   = data_q[p*TILE_W +: TILE_W];
            wr_planes[p] = plane_word[bit_sel];
        end
    end

    assign opaque = |wr_planes;

`ifdef SPRITE_LB_PRIORITY_EN
    logic [DEPTH-1:0] occ [2];

    assign occ_hit = occ[~old_v0][wr_addr];

    always_ff @(posedge CLK_96M) begin
        if (state_q == CLEAR) begin
            occ[0][clr_addr] <= 1'b0;
            occ[1][clr_addr] <= 1'b0;
        end
        if (rd_en) begin
            occ[old_v0][rd_addr] <= 1'b0;
        end
        if (pix_we) begin
            occ[~old_v0][wr_addr] <= 1'b1;
        end
    end
`else
    assign occ_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        pix_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                if (clr_addr == '1) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (wr.wr_req != wr_ack_q) begin
                    accept  = 1'b1;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                if (v0_edge) begin
                    state_d = IDLE;
                end else begin
                    pix_we = opaque && !occ_hit;
                    if (count == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge CLK_96M or posedge RESET) begin
        if (RESET) begin
            state_q  <= CLEAR;
            clr_addr <= '0;
            scan_pos <= ADDR_W'(SCAN_START);
            old_v0   <= 1'b0;
            count    <= '0;
            wr_ack_q <= 1'b0;
            data_q   <= '0;
            color_q  <= '0;
            pos_q    <= '0;
            flip_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            old_v0  <= V0;
            if (state_q == CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
            end
            if (v0_edge) begin
                scan_pos <= ADDR_W'(SCAN_START);
            end else if (CE_PIX) begin
                scan_pos <= scan_pos + 1'b1;
            end
            if (accept) begin
                wr_ack_q <= wr.wr_req;
                data_q   <= wr.data_in;
                color_q  <= wr.color_in;
                pos_q    <= wr.position_in;
                flip_q   <= wr.flip_in;
                count    <= CNT_W'(TILE_W);
            end else if (state_q == UNPACK) begin
                count <= v0_edge ? '0 : count - 1'b1;
            end
        end
    end

    // Sweep, scan-clear and writer may all fire in one clock; the writer only
    // touches the write bank and the scan only the read bank, and the sweep
    // never overlaps unpacking, so no two writes target the same word with
    // different data.
    always_ff @(posedge CLK_96M) begin
        if (state_q == CLEAR) begin
            mem[0][clr_addr] <= '0;
            mem[1][clr_addr] <= '0;
        end
        if (rd_en) begin
            mem[old_v0][rd_addr] <= '0;
        end
        if (pix_we) begin
            mem[~old_v0][wr_addr] <= {color_q, wr_planes};
        end
    end

    // Two-stage readout pipe; bank contents are undefined until the sweep has
    // passed, so reads during CLEAR are forced transparent.
    always_ff @(posedge CLK_96M or posedge RESET) begin
        if (RESET) begin
            rd_s1     <= '0;
            rd_v1     <= 1'b0;
            rd_s2     <= '0;
            rd_v2     <= 1'b0;
            pixel_out <= '0;
        end else begin
            rd_v1 <= rd_en;
            rd_s1 <= (state_q == CLEAR) ? '0 : mem[old_v0][rd_addr];
            rd_v2 <= rd_v1;
            rd_s2 <= rd_s1;
            if (rd_v2) begin
                pixel_out <= rd_s2;
            end
        end
    end
endmodule

// File: tb/tb_sprite_line_buffer_ng.sv
// -----------------------------------------------------------------------------
// tb_sprite_line_buffer_ng
// Directed bench: each CE_PIX issued pushes the hand-computed pixel for the
// address being read; a monitor pops and compares two clocks later.
// -----------------------------------------------------------------------------
module tb_sprite_line_buffer_ng;
    localparam int ADDR_W     = 10;
    localparam int TILE_W     = 16;
    localparam int PLANES     = 4;
    localparam int COLOR_BITS = 4;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int SCAN_START = 249;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       v0;
    logic       nl;
    logic [7:0] pixel_out;

    sprite_line_buffer_ng_if #(
        .ADDR_W(ADDR_W), .TILE_W(TILE_W), .PLANES(PLANES), .COLOR_BITS(COLOR_BITS)
    ) wr_if ();

    sprite_line_buffer_ng #(
        .ADDR_W(ADDR_W), .TILE_W(TILE_W), .PLANES(PLANES),
        .COLOR_BITS(COLOR_BITS), .SCAN_START(SCAN_START)
    ) dut (
        .CLK_96M   (clk),
        .RESET     (rst),
        .CE_PIX    (ce),
        .V0        (v0),
        .NL        (nl),
        .wr        (wr_if),
        .pixel_out (pixel_out)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] exp_q[$];
    logic [7:0]  exp_line [DEPTH];
    logic [2:0]  ce_hist = 3'b000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pixel_out reflects the CE_PIX issued two edges earlier.
    always @(posedge clk) begin
        ce_hist = {ce_hist[1:0], ce & ~rst};
        if (ce_hist[2]) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pixel_unexpected: got %0h expected no output", pixel_out);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check($sformatf("pixel@%0d", e[17:8]), {24'h0, pixel_out}, {24'h0, e[7:0]});
            end
        end
    end

    task automatic clear_exp();
        for (int i = 0; i < DEPTH; i++) exp_line[i] = 8'h00;
    endtask

    task automatic set_range(input int start, input int n, input logic [7:0] val);
        for (int i = 0; i < n; i++) exp_line[(start + i) % DEPTH] = val;
    endtask

    // One full line: scan_pos starts at SCAN_START after a V0 edge and wraps
    // back there after DEPTH strobes.
    task automatic scan_line(input bit mirror);
        int sp;
        int a;
        logic [9:0] a10;
        nl = mirror;
        for (int k = 0; k < DEPTH; k++) begin
            sp  = (SCAN_START + k) % DEPTH;
            a   = mirror ? (sp ^ (DEPTH - 1)) : sp;
            a10 = a[9:0];
            @(negedge clk);
            ce = 1'b1;
            exp_q.push_back({a10, exp_line[a]});
            @(negedge clk);
            ce = 1'b0;
        end
        repeat (4) @(negedge clk);
        nl = 1'b0;
    endtask

    task automatic toggle_v0();
        @(negedge clk);
        v0 = ~v0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] p0, input logic [3:0] col, input int pos,
                            input bit flp, output int lat);
        @(negedge clk);
        wr_if.data_in     = {48'h0, p0};
        wr_if.color_in    = col;
        wr_if.position_in = pos[9:0];
        wr_if.flip_in     = flp;
        wr_if.wr_req      = ~wr_if.wr_req;
        lat = 0;
        while (wr_if.wr_ack !== wr_if.wr_req && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (wr_if.busy !== 1'b0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, {31'h0, wr_if.busy}, 32'h0);
    endtask

    initial begin
        int n;
        int lat;
        rst = 1'b1; ce = 1'b0; v0 = 1'b0; nl = 1'b0;
        wr_if.wr_req = 1'b0; wr_if.data_in = '0; wr_if.color_in = '0;
        wr_if.position_in = '0; wr_if.flip_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_wr_ack", {31'h0, wr_if.wr_ack}, 32'h0);
        check("reset_busy",   {31'h0, wr_if.busy},   32'h1);
        check("reset_pixel",  {24'h0, pixel_out},    32'h0);
        rst = 1'b0;

        n = 0;
        while (wr_if.busy === 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("clear_sweep_len", n, DEPTH);

        // Both banks empty after the sweep.
        clear_exp();
        scan_line(1'b0);
        toggle_v0();
        scan_line(1'b0);
        toggle_v0();

        // V0=0 -> bank1 written; basic row, then clear-behind.
        do_write(16'hFFFF, 4'h5, 100, 1'b0, lat);
        check("ack_latency", lat, 1);
        wait_idle("busy_after_row");
        toggle_v0();
        clear_exp();
        set_range(100, 16, 8'h51);
        scan_line(1'b0);
        clear_exp();
        scan_line(1'b0);

        // Flip: V0=1 -> bank0.
        do_write(16'h8000, 4'h3, 0, 1'b1, lat);
        check("ack_latency_flip", lat, 1);
        wait_idle("busy_after_flip");
        toggle_v0();
        clear_exp();
        exp_line[15] = 8'h31;
        scan_line(1'b0);
        do_write(16'h8000, 4'h3, 0, 1'b0, lat);
        wait_idle("busy_after_noflip");
        toggle_v0();
        clear_exp();
        exp_line[0] = 8'h31;
        scan_line(1'b1);

        // Wrap past the top address; read bank must stay empty.
        do_write(16'hFFFF, 4'h7, 1020, 1'b0, lat);
        wait_idle("busy_after_wrap");
        clear_exp();
        scan_line(1'b0);
        toggle_v0();
        set_range(1020, 16, 8'h71);
        scan_line(1'b0);

        // V0 edge 5 clocks after acknowledge aborts the unpack.
        @(negedge clk);
        wr_if.data_in = {48'h0, 16'hFFFF}; wr_if.color_in = 4'h9;
        wr_if.position_in = 10'd200; wr_if.flip_in = 1'b0;
        wr_if.wr_req = ~wr_if.wr_req;
        @(posedge clk);
        #1;
        check("abort_ack", {31'h0, wr_if.wr_ack}, {31'h0, wr_if.wr_req});
        repeat (5) @(posedge clk);
        #1;
        check("abort_busy_before", {31'h0, wr_if.busy}, 32'h1);
        @(negedge clk);
        v0 = ~v0;
        @(posedge clk);
        #1;
        check("abort_ack_holds", {31'h0, wr_if.wr_ack}, {31'h0, wr_if.wr_req});
        check("abort_busy_drop", {31'h0, wr_if.busy}, 32'h0);
        repeat (2) @(negedge clk);
        clear_exp();
        set_range(200, 5, 8'h91);
        scan_line(1'b0);

        // Overlapping rows, second request queued behind the first.
        do_write(16'hFFFF, 4'h1, 0, 1'b0, lat);
        check("ack_latency_ovl", lat, 1);
        do_write(16'hFFFF, 4'h2, 8, 1'b0, lat);
        check("next_accept_delay", lat, TILE_W + 1);
        wait_idle("busy_after_ovl");
        toggle_v0();
        clear_exp();
        set_range(0, 8, 8'h11);
`ifdef SPRITE_LB_PRIORITY_EN
        set_range(8, 8, 8'h11);
`else
        set_range(8, 8, 8'h21);
`endif
        set_range(16, 8, 8'h21);
        scan_line(1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("queue_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sprite_line_buffer_ng.md
Name: sprite_line_buffer_ng

Overview:
- Parametrised double-buffered sprite line buffer for the M72 sprite path, running entirely in the CLK_96M domain.
- The sprite fetcher hands over one tile row per toggle handshake: PLANES bitplanes of TILE_W pixels, plus colour, X position and flip.
- The block unpacks the row one pixel per clock into the write bank. The other bank is read out on CE_PIX and cleared behind the scan.
- Over the previous generation it adds: generic depth/width, per-write flip, a programmable scan start, a reset clear sweep, a busy flag and optional first-opaque-wins priority.

Parameters:
- ADDR_W, 10, line address bits; each bank holds 2^ADDR_W pixels.
- TILE_W, 16, pixels per write request.
- PLANES, 4, bitplanes per pixel.
- COLOR_BITS, 4, palette bank bits stored with each pixel.
- SCAN_START, 249, scan_pos load value on every V0 edge.

Ports:
- CLK_96M  in  1  sole clock.
- RESET  in  1  asynchronous, active-high reset.
- CE_PIX  in  1  pixel strobe, synchronous to CLK_96M.
- V0  in  1  line parity; V0=0 reads bank0 and writes bank1, V0=1 the reverse.
- NL  in  1  flip readout; read address is scan_pos ^ {ADDR_W{NL}}.
- wr_req  in  1  toggle request.
- wr_ack  out  1  toggle acknowledge.
- data_in  in  PLANES*TILE_W  plane p occupies [p*TILE_W +: TILE_W]; bit TILE_W-1 is the leftmost pixel.
- color_in  in  COLOR_BITS  colour for the request.
- position_in  in  ADDR_W  X of the leftmost pixel.
- flip_in  in  1  1 = emit pixels in LSB-first order.
- busy  out  1  high during the clear sweep or while unpacking.
- pixel_out  out  COLOR_BITS+PLANES  format {colour, plane[PLANES-1..0]}; 0 = transparent.

Behaviour:
- Reset values: wr_ack=0, busy=1 (sweep starts), pixel_out=0, unpack count=0, scan_pos=SCAN_START, old_v0=0.
- State machine: CLEAR -> IDLE <-> UNPACK.
- CLEAR
  - Entered on RESET.
  - Writes 0 to address k of both banks at clock k, for k = 0 .. 2^ADDR_W-1.
  - Then moves to IDLE.
  - wr_req is not acknowledged during CLEAR; a pending toggle is accepted on the first IDLE clock.
- IDLE
  - When wr_req != wr_ack: latch data, colour, position and flip; set wr_ack <= wr_req; count <= TILE_W; go to UNPACK.
  - Acknowledge latency is 1 clock.
- UNPACK
  - One pixel per clock for TILE_W clocks.
  - Pixel i is taken from bit index (flip ? i : TILE_W-1-i) of every plane.
  - Destination address is position + i, modulo 2^ADDR_W; wrap past the top address is silent.
  - A pixel whose plane bits are all 0 is not written.
  - Back to IDLE when count reaches 0. A new request is never accepted before that (no back-to-back overlap); the earliest next acceptance is the clock after the last pixel.
- busy = (state != IDLE) || (wr_req != wr_ack).
- V0 edge (V0 != old_v0)
  - scan_pos <= SCAN_START; old_v0 <= V0.
  - Any in-flight UNPACK is aborted: remaining pixels are dropped, count <= 0, state <= IDLE. The already-given wr_ack stands.
  - A request accepted on the same clock as the edge targets the new write bank.
- Readout, on each CE_PIX with no V0 edge:
  - Read the read bank at scan_pos^NL mask, clear that same address (read-before-write), then scan_pos <= scan_pos+1 with wrap.
  - pixel_out updates 2 CLK_96M clocks after the CE_PIX clock and holds until the next update.
- Port split: the writer uses the write bank and the scan uses the read bank, so there is never a port conflict.
- CE_PIX during CLEAR: the scan pointer advances and pixel_out is 0.

Optional Feature:
- Macro: SPRITE_LB_PRIORITY_EN.
- Defined
  - Each bank carries a 2^ADDR_W-bit occupancy map.
  - An opaque write is suppressed if its address is already occupied, so the first opaque pixel wins (earlier objects have priority).
  - The occupancy bit is set on write and cleared by the scan clear and by CLEAR.
- Undefined
  - No occupancy storage; the last opaque write wins.

Test Plan:
- Reset then wait -> busy high for exactly 1024 clocks; both banks then read 0 over a full line.
- V0=0, write data planes {FFFF,0000,0000,0000}, colour 5, position 100, flip 0; toggle V0 and scan -> addresses 100..115 return 0x51, 99 and 116 return 0; a second line read returns all 0 (clear-behind).
- Plane0=0x8000 with flip=1, position 0 -> only address 15 is opaque; with flip=0 -> only address 0.
- Position 1020, plane0=FFFF -> addresses 1020..1023 and 0..11 written; no write spills into the read bank.
- V0 toggles 5 clocks after acknowledge -> exactly 5 pixels present in that bank; wr_ack equals wr_req; busy drops the next clock.
- Overlapping writes at positions 0 (colour 1) then 8 (colour 2) -> address 10 reads colour 1 with SPRITE_LB_PRIORITY_EN defined, colour 2 without.
